// File: rtl/vga_scanout_if.sv
// Pixel FIFO read-side bundle between the scan-out engine (master) and the FIFO (slave).
interface vga_scanout_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_rempty;
    logic              fifo_read;

    modport master (output fifo_read, input fifo_rdata, input fifo_rempty);
    modport slave  (input fifo_read, output fifo_rdata, output fifo_rempty);
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out: HS/VS/BLANK timing, FIFO pixel fetch, RGB565/888 decode, underflow tracking.
// Optional colour-bar generator enabled by `define VGA_SCANOUT_TESTPAT_EN.
module vga_scanout #(
    parameter int unsigned HDISP    = 640,
    parameter int unsigned HFP      = 16,
    parameter int unsigned HPULSE   = 96,
    parameter int unsigned HBP      = 48,
    parameter int unsigned VDISP    = 480,
    parameter int unsigned VFP      = 11,
    parameter int unsigned VPULSE   = 2,
    parameter int unsigned VBP      = 31,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_FMT  = 0,
    parameter int unsigned DATA_W   = 16,
    parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
    input  logic          vga_CLK,
    input  logic          rst,
    vga_scanout_if.master fifo,
    input  logic          uf_clr,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic          testpat,
`endif
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank,
    output logic          vga_sync,
    output logic          frame_start,
    output logic          underflow,
    output logic [15:0]   uf_cnt
);
    localparam int unsigned H_TOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned V_TOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);

    typedef enum logic {WAIT_FILL, RUN} state_t;

    state_t          state;
    logic [XW-1:0]   cnt_x;
    logic [YW-1:0]   cnt_y;
    logic            act1, hs1, vs1, uf1, run1;
    logic            active_c, hs_c, vs_c, origin_c, run_c, read_c, uf_c, tp_c, blank_c;
    logic [DATA_W-1:0] rdata;
    logic [23:0]     d24, rgb_c, pix_c;

`ifdef VGA_SCANOUT_TESTPAT_EN
    logic            tp1;
    logic [2:0]      bar1;
    logic [2:0]      bar_c;

    function automatic logic [23:0] bar_color(input logic [2:0] b);
        case (b)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    assign tp_c  = testpat;
    assign bar_c = 3'((32'(cnt_x) * 32'd8) / HDISP);
`else
    assign tp_c  = 1'b0;
`endif

    // Stage 0: raster decode from the counters
    assign active_c = (32'(cnt_x) < HDISP) && (32'(cnt_y) < VDISP);
    assign hs_c     = (32'(cnt_x) >= HDISP + HFP) && (32'(cnt_x) < HDISP + HFP + HPULSE);
    assign vs_c     = (32'(cnt_y) >= VDISP + VFP) && (32'(cnt_y) < VDISP + VFP + VPULSE);
    assign origin_c = (cnt_x == '0) && (cnt_y == '0);

    // The start pixel itself is fetched, so word 0 lands on pixel (0,0)
    assign run_c   = (state == RUN) || (origin_c && !fifo.fifo_rempty);
    assign read_c  = !rst && !tp_c && run_c && active_c && !fifo.fifo_rempty;
    assign uf_c    = !rst && !tp_c && run_c && active_c && fifo.fifo_rempty;
    assign fifo.fifo_read = read_c;
    assign vga_sync = 1'b0;

    // Stage 1 decode of the word returned by the FIFO
    assign rdata = fifo.fifo_rdata;
    assign d24   = 24'(rdata);

    always_comb begin
        if (PIX_FMT == 0)
            rgb_c = {d24[15:11], d24[15:13], d24[10:5], d24[10:9], d24[4:0], d24[4:2]};
        else
            rgb_c = d24;
        pix_c   = '0;
        blank_c = act1 && run1;
        if (act1 && run1)
            pix_c = uf1 ? UF_COLOR : rgb_c;
`ifdef VGA_SCANOUT_TESTPAT_EN
        if (tp1) begin
            blank_c = act1;
            pix_c   = act1 ? bar_color(bar1) : 24'h000000;
        end
`endif
    end

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            state       <= WAIT_FILL;
            cnt_x       <= '0;
            cnt_y       <= '0;
            act1        <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            uf1         <= 1'b0;
            run1        <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank   <= 1'b0;
            vga_hs      <= !HS_POL;
            vga_vs      <= !VS_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            uf_cnt      <= '0;
`ifdef VGA_SCANOUT_TESTPAT_EN
            tp1         <= 1'b0;
            bar1        <= '0;
`endif
        end else begin
            if (state == WAIT_FILL && origin_c && !fifo.fifo_rempty)
                state <= RUN;

            if (32'(cnt_x) == H_TOTAL - 1) begin
                cnt_x <= '0;
                cnt_y <= (32'(cnt_y) == V_TOTAL - 1) ? '0 : cnt_y + YW'(1);
            end else begin
                cnt_x <= cnt_x + XW'(1);
            end

            act1 <= active_c;
            hs1  <= hs_c;
            vs1  <= vs_c;
            uf1  <= uf_c;
            run1 <= run_c;
`ifdef VGA_SCANOUT_TESTPAT_EN
            tp1  <= tp_c;
            bar1 <= bar_c;
`endif
            {vga_r, vga_g, vga_b} <= pix_c;
            vga_blank   <= blank_c;
            vga_hs      <= hs1 ? HS_POL : !HS_POL;
            vga_vs      <= vs1 ? VS_POL : !VS_POL;
            frame_start <= origin_c;

            // A clear coinciding with a new underflow keeps that underflow
            if (uf_clr) begin
                underflow <= uf_c;
                uf_cnt    <= uf_c ? 16'd1 : 16'd0;
            end else if (uf_c) begin
                underflow <= 1'b1;
                if (uf_cnt != 16'hFFFF)
                    uf_cnt <= uf_cnt + 16'd1;
            end
        end
    end
endmodule
